// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data/register widths, opcodes, MEM-stage FSM state codes
// and an address range helper.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SHF  = 4'h5;
  localparam logic [3:0] OP_MUL  = 4'h6;
  localparam logic [3:0] OP_DIV  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LUI  = 4'h9;
  localparam logic [3:0] OP_LW   = 4'hA;
  localparam logic [3:0] OP_SW   = 4'hB;
  localparam logic [3:0] OP_BR   = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_SYS  = 4'hE;
  localparam logic [3:0] OP_NOP  = 4'hF;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // True when a full 16-bit address falls inside a memory of 'depth' words.
  function automatic logic addr_in_range(input logic [DATA_W-1:0] addr, input int depth);
    return int'({16'b0, addr}) < depth;
  endfunction

endpackage

// File: rtl/data_mem.sv
// Data memory: DEPTH x DW words, synchronous write, asynchronous read.
module data_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = DATA_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] ram [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      ram[addr] <= wdata;
    end
  end

  assign rdata = ram[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage with wait-state FSM plus the MEM/WB pipeline register.
// Optional MEM_BOUNDS_CHECK_EN: out-of-range accesses are suppressed and flagged on memFault.
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int AW          = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ALUResult_MEM,
  input  logic [DATA_W-1:0] R0D_MEM,
  input  logic [DATA_W-1:0] DataIn_MEM,
  input  logic [REG_W-1:0]  RA1_MEM,
  input  logic [3:0]        opcode_MEM,
  input  logic [3:0]        FN_Offset_MEM,
  input  logic              regWrite_MEM,
  input  logic              r0Write_MEM,
  input  logic              memRead_MEM,
  input  logic              memWrite_MEM,
  input  logic              memSource_MEM,
  output logic              stall_MEM,
  output logic [DATA_W-1:0] WBData_WB,
  output logic [DATA_W-1:0] R0D_WB,
  output logic [REG_W-1:0]  RA1_WB,
  output logic [3:0]        opcode_WB,
  output logic              regWrite_WB,
  output logic              r0Write_WB,
  output logic              memFault
);

  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [0:0]        state;
  logic [3:0]        cnt;
  logic              req;
  logic              complete;
  logic              in_range;
  logic              ram_we;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] load_data;
  logic              unused_fields;

  assign req = memRead_MEM | memWrite_MEM;

  // Reset forces the stall low in the same cycle so an aborted access never blocks upstream.
  always_comb begin
    stall_MEM = 1'b0;
    complete  = 1'b0;
    if (!reset && req) begin
      if (state == ST_WAIT) begin
        if (cnt == 4'd0) begin
          complete = 1'b1;
        end else begin
          stall_MEM = 1'b1;
        end
      end else if (WAIT_STATES == 0) begin
        complete = 1'b1;
      end else begin
        stall_MEM = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else if (state == ST_IDLE) begin
      if (req && (WAIT_STATES > 0)) begin
        state <= ST_WAIT;
        cnt   <= WAIT_INIT;
      end
    end else begin
      if (!req || (cnt == 4'd0)) begin
        state <= ST_IDLE;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

`ifdef MEM_BOUNDS_CHECK_EN
  logic fault_q;

  assign in_range = addr_in_range(ALUResult_MEM, DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (complete && !in_range) begin
      fault_q <= 1'b1;
    end
  end

  assign memFault = fault_q;
`else
  assign in_range = 1'b1;
  assign memFault = 1'b0;
`endif

  assign ram_we    = complete & memWrite_MEM & in_range;
  assign load_data = in_range ? rdata : '0;

  data_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DATA_W)
  ) u_data_mem (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ALUResult_MEM[AW-1:0]),
    .wdata (DataIn_MEM),
    .rdata (rdata)
  );

  // A stalled cycle loads a bubble: write enables drop, data fields keep their old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      WBData_WB   <= '0;
      R0D_WB      <= '0;
      RA1_WB      <= '0;
      opcode_WB   <= '0;
      regWrite_WB <= 1'b0;
      r0Write_WB  <= 1'b0;
    end else if (stall_MEM) begin
      regWrite_WB <= 1'b0;
      r0Write_WB  <= 1'b0;
    end else begin
      WBData_WB   <= memSource_MEM ? load_data : ALUResult_MEM;
      R0D_WB      <= R0D_MEM;
      RA1_WB      <= RA1_MEM;
      opcode_WB   <= opcode_MEM;
      regWrite_WB <= regWrite_MEM;
      r0Write_WB  <= r0Write_MEM;
    end
  end

  assign unused_fields = ^{FN_Offset_MEM, ALUResult_MEM};

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: one instance with 0 wait states, one with 3,
// directed scenarios plus random traffic checked against a transaction-level model.
module tb_mem_wb_stage;
  import cpu_pkg::*;

  localparam int DEPTH = 256;

  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] r0d;
    logic [15:0] din;
    logic [3:0]  ra1;
    logic [3:0]  opcode;
    logic [3:0]  fn;
    logic        regWrite;
    logic        r0Write;
    logic        memRead;
    logic        memWrite;
    logic        memSource;
  } txn_t;

  typedef struct packed {
    logic [15:0] wbData;
    logic [15:0] r0d;
    logic [3:0]  ra1;
    logic [3:0]  opcode;
    logic        regWrite;
    logic        r0Write;
  } wb_t;

  logic        clk = 1'b0;
  logic        reset;
  txn_t        bus [2];
  logic        stall [2];
  logic [15:0] wbData [2];
  logic [15:0] r0dWb [2];
  logic [3:0]  ra1Wb [2];
  logic [3:0]  opWb [2];
  logic        rwWb [2];
  logic        r0wWb [2];
  logic        fault [2];

  wb_t         expWb [2];
  logic        expFault [2];
  logic        expStall;
  logic        chkEn;
  int          sel;
  logic [15:0] mdlMem [2][256];
  int          tests = 0;
  int          fails = 0;
  int          stallSeen = 0;
  int          rwInStall = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DEPTH(DEPTH), .AW(8), .WAIT_STATES(0)) dutWs0 (
    .clk(clk), .reset(reset),
    .ALUResult_MEM(bus[0].alu), .R0D_MEM(bus[0].r0d), .DataIn_MEM(bus[0].din),
    .RA1_MEM(bus[0].ra1), .opcode_MEM(bus[0].opcode), .FN_Offset_MEM(bus[0].fn),
    .regWrite_MEM(bus[0].regWrite), .r0Write_MEM(bus[0].r0Write),
    .memRead_MEM(bus[0].memRead), .memWrite_MEM(bus[0].memWrite), .memSource_MEM(bus[0].memSource),
    .stall_MEM(stall[0]), .WBData_WB(wbData[0]), .R0D_WB(r0dWb[0]), .RA1_WB(ra1Wb[0]),
    .opcode_WB(opWb[0]), .regWrite_WB(rwWb[0]), .r0Write_WB(r0wWb[0]), .memFault(fault[0])
  );

  mem_wb_stage #(.DEPTH(DEPTH), .AW(8), .WAIT_STATES(3)) dutWs3 (
    .clk(clk), .reset(reset),
    .ALUResult_MEM(bus[1].alu), .R0D_MEM(bus[1].r0d), .DataIn_MEM(bus[1].din),
    .RA1_MEM(bus[1].ra1), .opcode_MEM(bus[1].opcode), .FN_Offset_MEM(bus[1].fn),
    .regWrite_MEM(bus[1].regWrite), .r0Write_MEM(bus[1].r0Write),
    .memRead_MEM(bus[1].memRead), .memWrite_MEM(bus[1].memWrite), .memSource_MEM(bus[1].memSource),
    .stall_MEM(stall[1]), .WBData_WB(wbData[1]), .R0D_WB(r0dWb[1]), .RA1_WB(ra1Wb[1]),
    .opcode_WB(opWb[1]), .regWrite_WB(rwWb[1]), .r0Write_WB(r0wWb[1]), .memFault(fault[1])
  );

  function automatic int wsOf(input int s);
    return (s == 1) ? 3 : 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of the selected instance against the model's expectations.
  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("stall_MEM", 32'(stall[sel]), 32'(expStall));
      checkOutput("WBData_WB", 32'(wbData[sel]), 32'(expWb[sel].wbData));
      checkOutput("R0D_WB", 32'(r0dWb[sel]), 32'(expWb[sel].r0d));
      checkOutput("RA1_WB", 32'(ra1Wb[sel]), 32'(expWb[sel].ra1));
      checkOutput("opcode_WB", 32'(opWb[sel]), 32'(expWb[sel].opcode));
      checkOutput("regWrite_WB", 32'(rwWb[sel]), 32'(expWb[sel].regWrite));
      checkOutput("r0Write_WB", 32'(r0wWb[sel]), 32'(expWb[sel].r0Write));
      checkOutput("memFault", 32'(fault[sel]), 32'(expFault[sel]));
    end
  end

  always @(negedge clk) begin
    if (stall[1] === 1'b1) begin
      stallSeen++;
      if (rwWb[1] !== 1'b0) rwInStall++;
    end
  end

  // Transaction-level model: memory array update and the write-back bundle it must produce.
  task automatic modelTxn(input int s, input txn_t t, output wb_t res, output logic flt);
    logic        inRange;
    logic [7:0]  a;
    logic [15:0] rd;
    a = t.alu[7:0];
`ifdef MEM_BOUNDS_CHECK_EN
    inRange = (t.alu < 16'(DEPTH));
`else
    inRange = 1'b1;
`endif
    rd  = inRange ? mdlMem[s][a] : 16'h0000;
    flt = (t.memRead || t.memWrite) && !inRange;
    if (t.memWrite && inRange) mdlMem[s][a] = t.din;
    res.wbData   = t.memSource ? rd : t.alu;
    res.r0d      = t.r0d;
    res.ra1      = t.ra1;
    res.opcode   = t.opcode;
    res.regWrite = t.regWrite;
    res.r0Write  = t.r0Write;
  endtask

  // Drives one transaction on instance s, holding it for the whole access.
  task automatic applyStimulus(input int s, input txn_t t);
    wb_t  res;
    logic flt;
    int   n;
    modelTxn(s, t, res, flt);
    n = (t.memRead || t.memWrite) ? wsOf(s) : 0;
    sel = s;
    bus[s] = t;
    chkEn = 1'b1;
    for (int k = 0; k <= n; k++) begin
      expStall = (k < n);
      @(posedge clk);
      #1;
      if (k < n) begin
        expWb[s].regWrite = 1'b0;
        expWb[s].r0Write  = 1'b0;
      end else begin
        expWb[s] = res;
        if (flt) expFault[s] = 1'b1;
      end
    end
  endtask

  task automatic idleCycles(input int n);
    bus[0] = '0;
    bus[1] = '0;
    expStall = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      expWb[0] = '0;
      expWb[1] = '0;
    end
  endtask

  function automatic txn_t mkTxn(input logic [15:0] alu, input logic [15:0] din, input logic rd,
                                 input logic wr, input logic src, input logic rw, input logic r0w,
                                 input logic [3:0] ra1, input logic [15:0] r0d);
    txn_t t;
    t = '0;
    t.alu = alu; t.din = din; t.memRead = rd; t.memWrite = wr; t.memSource = src;
    t.regWrite = rw; t.r0Write = r0w; t.ra1 = ra1; t.r0d = r0d;
    t.opcode = wr ? OP_SW : (rd ? OP_LW : OP_ADD);
    return t;
  endfunction

  function automatic txn_t randTxn();
    txn_t t;
    int   op;
    op = int'($urandom_range(0, 3));
    t = '0;
    t.r0d      = 16'($urandom);
    t.din      = 16'($urandom);
    t.ra1      = 4'($urandom);
    t.opcode   = 4'($urandom);
    t.fn       = 4'($urandom);
    t.regWrite = 1'($urandom);
    t.r0Write  = 1'($urandom);
    if (op == 0) begin
      t.alu = 16'($urandom);
    end else begin
      t.alu = {(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00), 4'h0, 4'($urandom)};
      t.memRead   = (op == 1) || (op == 3);
      t.memWrite  = (op == 2) || (op == 3);
      t.memSource = (op == 2) ? 1'($urandom) : 1'b1;
    end
    return t;
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    chkEn = 1'b0;
    sel = 0;
    expStall = 1'b0;
    bus[0] = '0;
    bus[1] = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      checkOutput("reset_stall", 32'(stall[s]), 32'd0);
      checkOutput("reset_wbData", 32'(wbData[s]), 32'd0);
      checkOutput("reset_r0d", 32'(r0dWb[s]), 32'd0);
      checkOutput("reset_ra1", 32'(ra1Wb[s]), 32'd0);
      checkOutput("reset_opcode", 32'(opWb[s]), 32'd0);
      checkOutput("reset_regWrite", 32'(rwWb[s]), 32'd0);
      checkOutput("reset_r0Write", 32'(r0wWb[s]), 32'd0);
      checkOutput("reset_memFault", 32'(fault[s]), 32'd0);
      expWb[s] = '0;
      expFault[s] = 1'b0;
    end
    reset = 1'b0;
    idleCycles(1);

    // Scenario 1: zero wait states, store then load back.
    applyStimulus(0, mkTxn(16'h0005, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0));
    applyStimulus(0, mkTxn(16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 16'h0));
    checkOutput("t1_wbData", 32'(wbData[0]), 32'h0000BEEF);
    checkOutput("t1_ra1", 32'(ra1Wb[0]), 32'd3);
    checkOutput("t1_regWrite", 32'(rwWb[0]), 32'd1);

    // Scenario 3: plain ALU op with R0 write.
    applyStimulus(0, mkTxn(16'h0042, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'h1234));
    checkOutput("t3_wbData", 32'(wbData[0]), 32'h00000042);
    checkOutput("t3_r0d", 32'(r0dWb[0]), 32'h00001234);
    checkOutput("t3_r0Write", 32'(r0wWb[0]), 32'd1);

    // Scenario 5: simultaneous read and write returns the old word.
    applyStimulus(0, mkTxn(16'h0007, 16'hAAAA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0));
    applyStimulus(0, mkTxn(16'h0007, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 16'h0));
    checkOutput("t5_rmw_old", 32'(wbData[0]), 32'h0000AAAA);
    applyStimulus(0, mkTxn(16'h0007, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 16'h0));
    checkOutput("t5_new", 32'(wbData[0]), 32'h00005555);

    // Scenario 6: address above DEPTH.
    applyStimulus(0, mkTxn(16'h0005, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0));
    applyStimulus(0, mkTxn(16'h0105, 16'h7777, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0));
    applyStimulus(0, mkTxn(16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 16'h0));
`ifdef MEM_BOUNDS_CHECK_EN
    checkOutput("t6_ram_unchanged", 32'(wbData[0]), 32'h00001234);
    checkOutput("t6_fault", 32'(fault[0]), 32'd1);
    applyStimulus(0, mkTxn(16'h0105, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 16'h0));
    checkOutput("t6_oob_load", 32'(wbData[0]), 32'h00000000);
`else
    checkOutput("t6_wrap_load", 32'(wbData[0]), 32'h00007777);
    checkOutput("t6_no_fault", 32'(fault[0]), 32'd0);
`endif
    idleCycles(1);

    // Scenario 2: three wait states on a load.
    applyStimulus(1, mkTxn(16'h0005, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0));
    stallSeen = 0;
    rwInStall = 0;
    applyStimulus(1, mkTxn(16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 16'h0));
    checkOutput("t2_stall_cycles", 32'(stallSeen), 32'd3);
    checkOutput("t2_rw_in_stall", 32'(rwInStall), 32'd0);
    checkOutput("t2_wbData", 32'(wbData[1]), 32'h0000BEEF);
    checkOutput("t2_regWrite", 32'(rwWb[1]), 32'd1);

    // Scenario 4: reset on the second stall cycle of a store.
    applyStimulus(1, mkTxn(16'h0009, 16'h2222, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0));
    idleCycles(1);
    chkEn = 1'b0;
    sel = 1;
    bus[1] = mkTxn(16'h0009, 16'h1111, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd6, 16'h4321);
    @(posedge clk);
    #1;
    checkOutput("t4_stall_before_reset", 32'(stall[1]), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("t4_stall_in_reset", 32'(stall[1]), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus[1] = '0;
    checkOutput("t4_wbData", 32'(wbData[1]), 32'd0);
    checkOutput("t4_r0d", 32'(r0dWb[1]), 32'd0);
    checkOutput("t4_regWrite", 32'(rwWb[1]), 32'd0);
    checkOutput("t4_r0Write", 32'(r0wWb[1]), 32'd0);
    checkOutput("t4_stall_after", 32'(stall[1]), 32'd0);
    for (int s = 0; s < 2; s++) begin
      expWb[s] = '0;
      expFault[s] = 1'b0;
    end
    applyStimulus(1, mkTxn(16'h0009, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd4, 16'h0));
    checkOutput("t4_no_write", 32'(wbData[1]), 32'h00002222);

    // Random traffic on both instances, low addresses seeded first.
    for (int s = 0; s < 2; s++) begin
      idleCycles(1);
      for (int a = 0; a < 16; a++) begin
        applyStimulus(s, mkTxn(16'(a), 16'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0));
      end
      for (int i = 0; i < 60; i++) begin
        applyStimulus(s, randTxn());
        if ($urandom_range(0, 4) == 0) idleCycles(1);
      end
    end
    idleCycles(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
